// File: rtl/bnn_filter_sequencer.sv
// bnn_filter_sequencer: time-multiplexes one xnor_popcount datapath over
// NUM_FILTERS binary filters for a single pixel window. The weight of filter
// f+1 is loaded in the same cycle filter f is evaluated, and the one-bit
// results are gathered into an activation vector.
module bnn_filter_sequencer #(
    parameter int unsigned KERNEL_SIZE = 16,
    parameter int unsigned NUM_FILTERS = 8,
    parameter int unsigned ADDR_W      = $clog2(NUM_FILTERS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [KERNEL_SIZE-1:0] in_pixels,
    output logic                   wrom_rd_en,
    output logic [ADDR_W-1:0]      wrom_addr,
    input  logic [KERNEL_SIZE-1:0] wrom_rdata,
    output logic                   dp_weight_wr,
    output logic [KERNEL_SIZE-1:0] dp_weight_in,
    output logic                   dp_input_plugin,
    output logic [KERNEL_SIZE-1:0] dp_pixels,
    input  logic                   dp_ready_out,
    input  logic                   dp_result_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_FILTERS-1:0] out_result,
    output logic                   busy
);

    // One extra bit keeps NUM_FILTERS itself representable in the counters.
    localparam int unsigned        CW       = ADDR_W + 1;
    localparam logic [CW-1:0]      NF       = CW'(NUM_FILTERS);
    localparam logic [CW-1:0]      K_LAST   = CW'(NUM_FILTERS - 1);
    localparam logic [ADDR_W-1:0]  RES_LAST = ADDR_W'(NUM_FILTERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                   state_q;
    logic [CW-1:0]            iss_q;
    logic [CW-1:0]            k_q;
    logic                     rd_q;
    logic [ADDR_W-1:0]        res_q;
    logic                     in_ready_q;
    logic                     busy_q;
    logic                     out_valid_q;
    logic                     wr_q;
    logic                     plugin_q;
    logic [KERNEL_SIZE-1:0]   pix_q;
    logic [NUM_FILTERS-1:0]   result_q;
    logic                     accept_c;

    // The filter-0 read goes out in the accept cycle itself, so the ROM
    // strobe combines the handshake with the registered follow-on reads.
    assign accept_c        = in_valid & in_ready_q;
    assign wrom_rd_en      = ~reset & (accept_c | rd_q);
    assign wrom_addr       = ADDR_W'(iss_q);
    assign dp_weight_in    = wrom_rdata;
    assign dp_weight_wr    = wr_q;
    assign dp_input_plugin = plugin_q;
    assign dp_pixels       = pix_q;
    assign in_ready        = in_ready_q;
    assign busy            = busy_q;
    assign out_valid       = out_valid_q;
    assign out_result      = result_q;

    // Sequencer state, ROM issue, datapath strobes and result gathering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            iss_q       <= '0;
            k_q         <= '0;
            rd_q        <= 1'b0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            wr_q        <= 1'b0;
            plugin_q    <= 1'b0;
            pix_q       <= '0;
            result_q    <= '0;
        end else begin
            // Follow-on reads for addresses 1..NUM_FILTERS-1; the address
            // stops at the last filter rather than wrapping.
            if (rd_q) begin
                if (iss_q + CW'(1) < NF) begin
                    iss_q <= iss_q + CW'(1);
                end else begin
                    rd_q <= 1'b0;
                end
            end

            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        pix_q      <= in_pixels;
                        result_q   <= '0;
                        res_q      <= '0;
                        iss_q      <= CW'(1);
                        rd_q       <= 1'b1;
                        wr_q       <= 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= PRIME;
                    end
                end
                PRIME: begin
                    k_q      <= '0;
                    plugin_q <= 1'b1;
                    wr_q     <= 1'b1;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (k_q == K_LAST) begin
                        plugin_q <= 1'b0;
                        wr_q     <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        k_q  <= k_q + CW'(1);
                        wr_q <= (k_q + CW'(2) < NF);
                    end
                end
                DRAIN: begin
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        iss_q       <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Capture overrides the RUN/DRAIN transition once the last bit lands.
            if ((state_q == RUN || state_q == DRAIN) && dp_ready_out) begin
                result_q[res_q] <= dp_result_out;
                if (res_q == RES_LAST) begin
                    out_valid_q <= 1'b1;
                    plugin_q    <= 1'b0;
                    wr_q        <= 1'b0;
                    rd_q        <= 1'b0;
                    state_q     <= DONE;
                end else begin
                    res_q <= res_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule
